// File: rtl/dma_pkg.sv
// Shared DMA types: descriptor address/length, queue entry, channel state.
package dma_pkg;

    typedef logic [31:0] desc_addr_t;
    typedef logic [15:0] desc_num_t;

    localparam int DMA_DESC_FIFO_DEPTH = 4;

    typedef struct packed {
        desc_addr_t src;
        desc_addr_t dst;
        desc_num_t  len;
        logic       last;
    } desc_entry_t;

    typedef enum logic {
        CH_IDLE,
        CH_BUSY
    } ch_state_t;

endpackage

// File: rtl/dma_desc_fifo_mem.sv
// Descriptor storage: DEPTH entries, one write port, one async read port.
module dma_desc_fifo_mem
    import dma_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  desc_entry_t   wdata,
    input  logic [AW-1:0] raddr,
    output desc_entry_t   rdata
);

    desc_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/dma_desc_fifo.sv
// DMA descriptor queue with single-outstanding issue channel and irq logic.
// Optional same-cycle bypass into an empty queue: VENUSDMA_DESC_BYPASS_EN.
module dma_desc_fifo
    import dma_pkg::*;
#(
    parameter int DEPTH = DMA_DESC_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 push_i,
    input  logic                 push_last_i,
    input  desc_addr_t           push_src_i,
    input  desc_addr_t           push_dst_i,
    input  desc_num_t            push_len_i,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                 desc_valid_o,
    input  logic                 desc_ready_i,
    output desc_addr_t           desc_src_o,
    output desc_addr_t           desc_dst_o,
    output desc_num_t            desc_len_o,
    output logic                 desc_last_o,
    input  logic                 done_i,
    input  logic                 error_i,
    output logic                 busy_o,
    output logic                 irq_o,
    output logic                 ovf_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    ch_state_t     state_q, state_d;
    logic          last_q, irq_q, ovf_q;
    desc_entry_t   push_e, head, out_e;
    logic          bypass, issue, pop_mem, flush, done_ok, push_ok, wr_en;

    assign push_e = '{src: push_src_i, dst: push_dst_i,
                      len: push_len_i, last: push_last_i};

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign busy_o  = (state_q == CH_BUSY);
    assign irq_o   = irq_q;
    assign ovf_o   = ovf_q;

`ifdef VENUSDMA_DESC_BYPASS_EN
    assign bypass = push_i && empty_o && !busy_o;
`else
    assign bypass = 1'b0;
`endif

    assign desc_valid_o = (!empty_o && !busy_o) || bypass;
    assign out_e = !desc_valid_o ? '0 : (bypass ? push_e : head);

    assign desc_src_o  = out_e.src;
    assign desc_dst_o  = out_e.dst;
    assign desc_len_o  = out_e.len;
    assign desc_last_o = out_e.last;

    assign issue   = desc_valid_o && desc_ready_i;
    assign pop_mem = issue && !bypass;
    assign flush   = error_i && busy_o;
    assign done_ok = done_i && busy_o;
    assign push_ok = push_i && !full_o && !flush;
    // A bypassed descriptor taken this cycle never touches storage
    assign wr_en   = push_ok && !(bypass && desc_ready_i);

    dma_desc_fifo_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (wr_en),
        .waddr(wr_ptr),
        .wdata(push_e),
        .raddr(rd_ptr),
        .rdata(head)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CH_IDLE: if (issue) state_d = CH_BUSY;
            CH_BUSY: if (flush || done_ok) state_d = CH_IDLE;
            default: state_d = CH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= CH_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
            irq_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + AW'(1);
                if (pop_mem) rd_ptr <= rd_ptr + AW'(1);
                count_q <= count_q + CW'(wr_en) - CW'(pop_mem);
            end
            if (issue) last_q <= out_e.last;
            irq_q <= flush || (done_ok && last_q);
            if (push_i && full_o && !flush) ovf_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dma_desc_fifo.sv
// Self-checking bench for dma_desc_fifo: queue model plus directed checks.
module tb_dma_desc_fifo;
    import dma_pkg::*;

    localparam int D = 4;
`ifdef VENUSDMA_DESC_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       push_i = 0, push_last_i = 0;
    desc_addr_t push_src_i = '0, push_dst_i = '0;
    desc_num_t  push_len_i = '0;
    logic       full_o, empty_o;
    logic [2:0] count_o;
    logic       desc_valid_o, desc_ready_i = 0;
    desc_addr_t desc_src_o, desc_dst_o;
    desc_num_t  desc_len_o;
    logic       desc_last_o;
    logic       done_i = 0, error_i = 0;
    logic       busy_o, irq_o, ovf_o;

    int n_chk = 0;
    int n_fail = 0;

    dma_desc_fifo #(.DEPTH(D)) dut (
        .clk(clk), .rstn(rstn),
        .push_i(push_i), .push_last_i(push_last_i),
        .push_src_i(push_src_i), .push_dst_i(push_dst_i),
        .push_len_i(push_len_i),
        .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
        .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready_i),
        .desc_src_o(desc_src_o), .desc_dst_o(desc_dst_o),
        .desc_len_o(desc_len_o), .desc_last_o(desc_last_o),
        .done_i(done_i), .error_i(error_i),
        .busy_o(busy_o), .irq_o(irq_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a plain queue plus channel flags
    desc_entry_t mq[$];
    bit m_busy, m_last, m_irq, m_ovf;

    function automatic desc_entry_t push_ent();
        return '{src: push_src_i, dst: push_dst_i, len: push_len_i, last: push_last_i};
    endfunction

    function automatic bit m_valid();
        return (mq.size() != 0 && !m_busy) ||
               (BYP && push_i && mq.size() == 0 && !m_busy);
    endfunction

    always @(posedge clk or negedge rstn) begin : model
        bit was_full, v, byp_take;
        desc_entry_t e;
        if (!rstn) begin
            mq.delete();
            m_busy = 0; m_last = 0; m_irq = 0; m_ovf = 0;
        end else begin
            was_full = (mq.size() == D);
            v = m_valid();
            byp_take = v && desc_ready_i && mq.size() == 0;
            m_irq = 0;
            if (m_busy && error_i) begin
                mq.delete();
                m_busy = 0;
                m_irq = 1;
            end else begin
                if (m_busy && done_i) begin
                    m_irq = m_last;
                    m_busy = 0;
                end else if (v && desc_ready_i) begin
                    e = byp_take ? push_ent() : mq.pop_front();
                    m_busy = 1;
                    m_last = e.last;
                end
                if (push_i) begin
                    if (was_full) m_ovf = 1;
                    else if (!byp_take) mq.push_back(push_ent());
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        desc_entry_t h;
        chk("count", count_o, mq.size());
        chk("empty", empty_o, mq.size() == 0);
        chk("full", full_o, mq.size() == D);
        chk("valid", desc_valid_o, m_valid());
        chk("busy", busy_o, m_busy);
        chk("irq", irq_o, m_irq);
        chk("ovf", ovf_o, m_ovf);
        if (m_valid()) begin
            h = (mq.size() != 0) ? mq[0] : push_ent();
            chk("src", desc_src_o, h.src);
            chk("dst", desc_dst_o, h.dst);
            chk("len", desc_len_o, h.len);
            chk("last", desc_last_o, h.last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    task automatic clr();
        push_i = 0; push_last_i = 0; desc_ready_i = 0;
        done_i = 0; error_i = 0;
        push_src_i = '0; push_dst_i = '0; push_len_i = '0;
    endtask

    task automatic do_reset();
        clr();
        rstn = 0;
        repeat (2) tick();
        rstn = 1;
        tick();
    endtask

    task automatic set_push(input int s, input int d, input int l, input bit last);
        push_i = 1;
        push_src_i = desc_addr_t'(s);
        push_dst_i = desc_addr_t'(d);
        push_len_i = desc_num_t'(l);
        push_last_i = last;
    endtask

    task automatic push(input int s, input int d, input int l, input bit last);
        set_push(s, d, l, last);
        tick();
        push_i = 0;
    endtask

    initial begin
        // Reset values and single descriptor round trip
        do_reset();
        look();
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_valid", desc_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_irq", irq_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_src", desc_src_o, 0);
        chk("rst_len", desc_len_o, 0);
        set_push(32'h1000, 32'h2000, 64, 1);
        look();
        chk("t1_lat_valid", desc_valid_o, BYP ? 1 : 0);
        tick();
        push_i = 0;
        look();
        chk("t1_valid", desc_valid_o, 1);
        chk("t1_src", desc_src_o, 32'h1000);
        chk("t1_dst", desc_dst_o, 32'h2000);
        chk("t1_len", desc_len_o, 64);
        chk("t1_count", count_o, 1);
        desc_ready_i = 1;
        tick();
        desc_ready_i = 0;
        look();
        chk("t1_busy", busy_o, 1);
        chk("t1_nvalid", desc_valid_o, 0);
        chk("t1_count0", count_o, 0);
        done_i = 1;
        tick();
        done_i = 0;
        look();
        chk("t1_irq", irq_o, 1);
        chk("t1_idle", busy_o, 0);
        tick();
        look();
        chk("t1_irq_off", irq_o, 0);

        // Overflow on fifth push
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(32'h100 * i, 32'h200 * i, i + 1, 0);
            if (i == 3) begin
                look();
                chk("t2_full4", full_o, 1);
                chk("t2_cnt4", count_o, 4);
                chk("t2_ovf4", ovf_o, 0);
            end
        end
        look();
        chk("t2_ovf", ovf_o, 1);
        chk("t2_count", count_o, 4);
        chk("t2_head", desc_src_o, 32'h0);

        // Irq only for the last descriptor of a chain
        do_reset();
        push(32'hA0, 32'hB0, 4, 0);
        push(32'hA1, 32'hB1, 5, 0);
        push(32'hA2, 32'hB2, 6, 1);
        for (int i = 0; i < 3; i++) begin
            desc_ready_i = 1;
            tick();
            desc_ready_i = 0;
            look();
            chk("t3_busy", busy_o, 1);
            done_i = 1;
            tick();
            done_i = 0;
            look();
            chk("t3_irq", irq_o, (i == 2) ? 1 : 0);
            tick();
        end

        // Error wins over done and flushes queue
        do_reset();
        push(32'h10, 32'h20, 1, 0);
        push(32'h11, 32'h21, 2, 0);
        push(32'h12, 32'h22, 3, 0);
        desc_ready_i = 1;
        tick();
        desc_ready_i = 0;
        look();
        chk("t4_count2", count_o, 2);
        error_i = 1;
        done_i = 1;
        tick();
        error_i = 0;
        done_i = 0;
        look();
        chk("t4_irq", irq_o, 1);
        chk("t4_count", count_o, 0);
        chk("t4_busy", busy_o, 0);
        tick();
        look();
        chk("t4_irq_once", irq_o, 0);

        // Push into full queue while popping is still dropped
        do_reset();
        for (int i = 0; i < 4; i++) push(32'h300 + i, 32'h400 + i, 8, 0);
        set_push(32'h3FF, 32'h4FF, 9, 1);
        desc_ready_i = 1;
        tick();
        clr();
        look();
        chk("t5_count", count_o, 3);
        chk("t5_ovf", ovf_o, 1);
        chk("t5_busy", busy_o, 1);

        // Reset mid-operation
        do_reset();
        push(32'h50, 32'h60, 1, 1);
        push(32'h51, 32'h61, 2, 1);
        push(32'h52, 32'h62, 3, 1);
        desc_ready_i = 1;
        tick();
        desc_ready_i = 0;
        look();
        chk("t6_busy", busy_o, 1);
        chk("t6_count", count_o, 2);
        rstn = 0;
        #1;
        chk("t6_rcount", count_o, 0);
        chk("t6_rempty", empty_o, 1);
        chk("t6_rfull", full_o, 0);
        chk("t6_rvalid", desc_valid_o, 0);
        chk("t6_rbusy", busy_o, 0);
        chk("t6_rirq", irq_o, 0);
        chk("t6_rovf", ovf_o, 0);
        chk("t6_rsrc", desc_src_o, 0);
        tick();
        rstn = 1;
        repeat (3) tick();
        look();
        chk("t6_noirq", irq_o, 0);

`ifdef VENUSDMA_DESC_BYPASS_EN
        do_reset();
        desc_ready_i = 1;
        set_push(32'h7000, 32'h8000, 16, 1);
        look();
        chk("byp_valid", desc_valid_o, 1);
        chk("byp_src", desc_src_o, 32'h7000);
        chk("byp_count", count_o, 0);
        tick();
        clr();
        look();
        chk("byp_busy", busy_o, 1);
        chk("byp_count0", count_o, 0);
        done_i = 1;
        tick();
        done_i = 0;
        look();
        chk("byp_irq", irq_o, 1);
`endif

        // Mixed traffic to wrap pointers
        do_reset();
        for (int i = 0; i < 24; i++) begin
            push_i = (i % 3) != 2;
            push_src_i = desc_addr_t'(32'hC000 + i);
            push_dst_i = desc_addr_t'(32'hD000 + i);
            push_len_i = desc_num_t'(i);
            push_last_i = i[0];
            desc_ready_i = (i % 4) != 1;
            done_i = (i % 2) == 1;
            tick();
        end
        clr();
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_desc_fifo.md
DMA_DESC_FIFO -- requirements
Module: dma_desc_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, descriptor queue entries; power of 2, 2..16.
REQ-002 SHALL have port clk  in  1  clock; all state on rising edge.
REQ-003 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port push_i  in  1  one-cycle descriptor push strobe from CSR control stage.
REQ-005 SHALL have port push_last_i  in  1  descriptor is last of scatter chain.
REQ-006 SHALL have ports push_src_i / push_dst_i  in  desc_addr_t  source / destination address; push_len_i  in  desc_num_t  length.
REQ-007 SHALL have port full_o  out  1  queue full (feeds CSR status bit 1).
REQ-008 SHALL have ports empty_o  out  1; count_o  out  $clog2(DEPTH)+1  occupied entries.
REQ-009 SHALL have ports desc_valid_o  out  1; desc_ready_i  in  1; desc_src_o, desc_dst_o  out  desc_addr_t; desc_len_o  out  desc_num_t; desc_last_o  out  1: issue channel to transfer engine.
REQ-010 SHALL have ports done_i  in  1  engine finished issued descriptor; error_i  in  1  engine aborted it.
REQ-011 SHALL have ports busy_o  out  1  descriptor outstanding; irq_o  out  1  L1 scheduler interrupt pulse; ovf_o  out  1  sticky push-while-full.

Function
REQ-012 SHALL store pushes in FIFO order; push accepted iff push_i && !full_o; full_o = (count_o == DEPTH), evaluated at start of cycle, even if pop occurs same cycle.
REQ-013 SHALL set ovf_o on push_i && full_o; dropped descriptor discarded, ovf_o held until reset.
REQ-014 SHALL drive desc_valid_o = !empty_o && !busy_o; head fields on desc_* stable while desc_valid_o && !desc_ready_i.
REQ-015 SHALL pop head on desc_valid_o && desc_ready_i; next cycle busy_o=1, head's last flag latched internally.
REQ-016 SHALL at most one descriptor outstanding; no desc_valid_o while busy_o.
REQ-017 SHALL on done_i while busy_o clear busy_o next cycle; assert irq_o exactly one cycle, next cycle, iff latched last flag = 1.
REQ-018 SHALL on error_i while busy_o clear busy_o, pulse irq_o one cycle, flush all queued entries (count_o=0 next cycle).
REQ-019 SHALL give error_i priority over done_i same cycle; flush priority over same-cycle push (push discarded, ovf_o unaffected).
REQ-020 SHALL ignore done_i/error_i when busy_o=0.
REQ-021 SHALL keep count_o unchanged on simultaneous accepted push and pop; pointers wrap modulo DEPTH.
REQ-022 SHALL, without bypass, have push-to-desc_valid_o latency 1 cycle from empty.

Reset
REQ-023 SHALL on rstn low: pointers, count_o=0, empty_o=1, full_o=0, desc_valid_o=0, busy_o=0, irq_o=0, ovf_o=0, desc_* outputs 0, latched last=0.
REQ-024 SHALL discard queued and outstanding descriptors on reset mid-operation; no irq_o after release.

Configuration
REQ-025 SHALL support macro VENUSDMA_DESC_BYPASS_EN: when defined, push into empty queue with !busy_o drives desc_valid_o and desc_* combinationally same cycle; if desc_ready_i=1 that cycle, descriptor issued without occupying storage (count_o stays 0).
REQ-026 SHALL, with VENUSDMA_DESC_BYPASS_EN undefined, always write storage first; latency per REQ-022.

Structure
REQ-027 SHALL take desc_addr_t, desc_num_t from dma_pkg; SHALL add dma_pkg typedef desc_entry_t {src, dst, len, last} and constant DMA_DESC_FIFO_DEPTH=4.
REQ-028 SHALL instantiate one sub-module dma_desc_fifo_mem (DEPTH x desc_entry_t register array, one write port, one async read port); control and irq logic in top.

Verification
REQ-029 SHALL test: push src=0x1000 dst=0x2000 len=64 last=1, ready=1 -> valid cycle 1, pop, busy=1; done_i -> irq_o one cycle, busy=0.
REQ-030 SHALL test: DEPTH=4, 5 pushes, ready=0 -> full_o=1 after 4th, 5th dropped, ovf_o=1, count_o=4.
REQ-031 SHALL test: 3 pushes last=0,0,1 -> done after 1st and 2nd give no irq_o; done after 3rd gives one irq_o.
REQ-032 SHALL test: 3 queued, first issued, error_i=1 and done_i=1 same cycle -> irq_o once, count_o=0, busy_o=0.
REQ-033 SHALL test: full queue, push+pop same cycle -> push dropped, ovf_o=1, count_o=3.
REQ-034 SHALL test: rstn low with busy_o=1 and 2 queued -> all outputs per REQ-023; with VENUSDMA_DESC_BYPASS_EN, push into empty with ready=1 -> desc_valid_o same cycle, count_o stays 0.
